// File: rtl/alu_pkg.sv
// alu_pkg: shared op enum, aluop/funct codes and the mult/div FSM states.
// The StDiv state only exists when ALU_MULDIV_DIV_EN is defined.
package alu_pkg;

  // aluop codes from the main decoder
  localparam logic [1:0] AluopAdd   = 2'b00;
  localparam logic [1:0] AluopSub   = 2'b01;
  localparam logic [1:0] AluopRtype = 2'b10;
  localparam logic [1:0] AluopSlt   = 2'b11;

  // R-type function field codes
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMflo = 6'b010010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnMulu = 6'b011001;
  localparam logic [5:0] FnDiv  = 6'b011010;
  localparam logic [5:0] FnDivu = 6'b011011;

  typedef enum logic [4:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt, OpSltu, OpSllv, OpSrlv, OpSrav,
    OpMfhi, OpMflo, OpMul, OpMulu, OpDiv, OpDivu, OpIll
  } alu_op_e;

`ifdef ALU_MULDIV_DIV_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} muldiv_state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StFin} muldiv_state_e;
`endif

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: 1 bit/cycle shift-add multiplier and restoring divider on operand magnitudes.
// done is combinational in the final busy cycle; hi/lo then hold the sign-corrected result.
// Divider datapath is only built when ALU_MULDIV_DIV_EN is defined.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic                   busy_q;
  logic [CW-1:0]          cnt_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [2*WIDTH-1:0]     step_nxt;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       opb_q;
  logic                   neg_q;
  logic                   rneg_q;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [WIDTH:0]         mul_sum;

  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

`ifdef ALU_MULDIV_DIV_EN
  logic             div_q;
  logic             div0_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             div_ge;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    step_nxt = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_sh - {1'b0, opb_q};
    div_ge  = rem_sh >= {1'b0, opb_q};
    if (div_q) begin
      step_nxt = {(div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  // Final-cycle result with sign correction
  always_comb begin
    prod = neg_q ? -step_nxt : step_nxt;
    hi   = prod[2*WIDTH-1:WIDTH];
    lo   = prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
    quo  = step_nxt[WIDTH-1:0];
    rem  = step_nxt[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // quotient sign from a^b, remainder sign follows the dividend
      lo = neg_q ? -quo : quo;
      hi = rneg_q ? -rem : rem;
      if (div0_q) begin
        lo = '1;
        hi = a_q;
      end
    end
    done = busy_q && ((cnt_q == CW'(1)) || div0_q);
`else
    done = busy_q && (cnt_q == CW'(1));
`endif
  end

  // Operand capture on start, then one iteration per cycle until done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      div_q  <= 1'b0;
      div0_q <= 1'b0;
      a_q    <= '0;
`endif
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(WIDTH);
      acc_q  <= {{WIDTH{1'b0}}, mag_a};
      opb_q  <= mag_b;
      neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_q <= is_signed && a[WIDTH-1];
`ifdef ALU_MULDIV_DIV_EN
      div_q  <= is_div;
      div0_q <= is_div && (b == '0);
      a_q    <= a;
`endif
    end else if (busy_q) begin
      acc_q <= step_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: EX-stage ALU with registered result plus iterative mult/div into HI/LO.
// Define ALU_MULDIV_DIV_EN to build div/divu; otherwise those functs decode as illegal.
module alu_muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_o,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             done_o
);
  localparam int unsigned SHW = $clog2(WIDTH);

  muldiv_state_e    state_q, state_d;
  alu_op_e          op_dec;
  logic             accept;
  logic             is_muldiv;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             valid_q, zero_q, illegal_q;
  logic [WIDTH-1:0] result_q;
  logic             seq_start, seq_done, hilo_we;
  logic [WIDTH-1:0] seq_hi, seq_lo;

  function automatic alu_op_e decode(input logic [1:0] op, input logic [5:0] fn);
    alu_op_e d;
    d = OpIll;
    case (op)
      AluopAdd: d = OpAdd;
      AluopSub: d = OpSub;
      AluopSlt: d = OpSlt;
      default: begin
        case (fn)
          FnAdd, FnAddu: d = OpAdd;
          FnSub, FnSubu: d = OpSub;
          FnAnd:  d = OpAnd;
          FnOr:   d = OpOr;
          FnXor:  d = OpXor;
          FnNor:  d = OpNor;
          FnSlt:  d = OpSlt;
          FnSltu: d = OpSltu;
          FnSllv: d = OpSllv;
          FnSrlv: d = OpSrlv;
          FnSrav: d = OpSrav;
          FnMfhi: d = OpMfhi;
          FnMflo: d = OpMflo;
          FnMult: d = OpMul;
          FnMulu: d = OpMulu;
`ifdef ALU_MULDIV_DIV_EN
          FnDiv:  d = OpDiv;
          FnDivu: d = OpDivu;
`endif
          default: d = OpIll;
        endcase
      end
    endcase
    return d;
  endfunction

  assign op_dec    = decode(aluop, funct);
  assign ready_o   = (state_q == StIdle) || (state_q == StFin);
  assign done_o    = (state_q == StFin);
  assign accept    = valid_i && ready_o;
  assign is_muldiv = (op_dec == OpMul) || (op_dec == OpMulu) ||
                     (op_dec == OpDiv) || (op_dec == OpDivu);

  // Single-cycle ALU datapath; illegal ops fall through to zero
  always_comb begin
    alu_res = '0;
    case (op_dec)
      OpAdd:  alu_res = a + b;
      OpSub:  alu_res = a - b;
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpNor:  alu_res = ~(a | b);
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OpSllv: alu_res = b << a[SHW-1:0];
      OpSrlv: alu_res = b >> a[SHW-1:0];
      OpSrav: alu_res = $unsigned($signed(b) >>> a[SHW-1:0]);
      OpMfhi: alu_res = hi_q;
      OpMflo: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Registered single-cycle result; mult/div never produce a valid_o pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= accept && !is_muldiv;
      illegal_q <= accept && (op_dec == OpIll);
      if (accept && !is_muldiv) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end
    end
  end

  assign valid_o = valid_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

  // Mult/div FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Mult/div FSM next state; FIN accepts new work like IDLE
  always_comb begin
    state_d   = state_q;
    seq_start = 1'b0;
    hilo_we   = 1'b0;
    case (state_q)
      StIdle, StFin: begin
        state_d = StIdle;
        if (accept && ((op_dec == OpMul) || (op_dec == OpMulu))) begin
          state_d   = StMul;
          seq_start = 1'b1;
        end
`ifdef ALU_MULDIV_DIV_EN
        if (accept && ((op_dec == OpDiv) || (op_dec == OpDivu))) begin
          state_d   = StDiv;
          seq_start = 1'b1;
        end
`endif
      end
`ifdef ALU_MULDIV_DIV_EN
      StMul, StDiv: begin
`else
      StMul: begin
`endif
        if (seq_done) begin
          state_d = StFin;
          hilo_we = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // HI/LO are written as the engine finishes, so FIN already sees them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= seq_hi;
      lo_q <= seq_lo;
    end
  end

  muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (seq_start),
    .is_signed ((op_dec == OpMul) || (op_dec == OpDiv)),
    .is_div    ((op_dec == OpDiv) || (op_dec == OpDivu)),
    .a         (a),
    .b         (b),
    .done      (seq_done),
    .hi        (seq_hi),
    .lo        (seq_lo)
  );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: randomized self-checking bench for alu_muldiv_ctrl (WIDTH=32).
// Expectations come from an arithmetic reference model of HI/LO and each op.
module tb_alu_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_i;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         ready_o, valid_o, zero, illegal, done_o;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  alu_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .aluop   (aluop),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .valid_o (valid_o),
    .result  (result),
    .zero    (zero),
    .illegal (illegal),
    .done_o  (done_o)
  );

  function automatic bit div_en();
`ifdef ALU_MULDIV_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model for single-cycle ops
  function automatic void model_alu(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic ill);
    ill = 1'b0;
    r = '0;
    case (op)
      2'd0: r = x + y;
      2'd1: r = x - y;
      2'd3: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: begin
        case (fn)
          6'h20, 6'h21: r = x + y;
          6'h22, 6'h23: r = x - y;
          6'h24: r = x & y;
          6'h25: r = x | y;
          6'h26: r = x ^ y;
          6'h27: r = ~(x | y);
          6'h2A: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          6'h2B: r = (x < y) ? 32'd1 : 32'd0;
          6'h04: r = y << x[4:0];
          6'h06: r = y >> x[4:0];
          6'h07: r = $unsigned($signed(y) >>> x[4:0]);
          6'h10: r = m_hi;
          6'h12: r = m_lo;
          default: ill = 1'b1;
        endcase
      end
    endcase
  endfunction

  // Reference model for mult/div: HI/LO and accept->done_o latency
  function automatic void model_muldiv(input logic [5:0] fn, input logic [31:0] x,
                                       input logic [31:0] y, output logic [31:0] hi,
                                       output logic [31:0] lo, output int lat);
    logic signed [63:0] sx, sy;
    logic [63:0] p;
    int qi, ri;
    lat = 33;
    hi = '0;
    lo = '0;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (fn)
      6'h18: begin p = sx * sy; hi = p[63:32]; lo = p[31:0]; end
      6'h19: begin p = {32'd0, x} * {32'd0, y}; hi = p[63:32]; lo = p[31:0]; end
      6'h1A: begin
        if (y == 0) begin lo = '1; hi = x; lat = 2; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo = x; hi = '0; end
        else begin qi = $signed(x) / $signed(y); ri = $signed(x) % $signed(y); lo = qi; hi = ri; end
      end
      default: begin
        if (y == 0) begin lo = '1; hi = x; lat = 2; end
        else begin lo = x / y; hi = x % y; end
      end
    endcase
  endfunction

  // Stimulus: offer one op, return what the DUT shows the next cycle
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x,
                        input logic [31:0] y, output logic v, output logic [31:0] r,
                        output logic z, output logic il);
    @(negedge clk);
    aluop = op; funct = fn; a = x; b = y; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    v = valid_o; r = result; z = zero; il = illegal;
  endtask

  // Stimulus: run a mult/div, then read HI and LO starting in the done_o cycle
  task automatic run_muldiv(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y,
                            output int rlow, output int vcnt, output int dcyc,
                            output logic [31:0] h, output logic [31:0] l);
    rlow = 0; vcnt = 0; dcyc = -1; h = 'x; l = 'x;
    @(negedge clk);
    aluop = 2'b10; funct = fn; a = x; b = y; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; a = $urandom; b = $urandom;
    for (int c = 1; c <= 100; c++) begin
      if (done_o) begin dcyc = c; break; end
      if (!ready_o) rlow++;
      if (valid_o) vcnt++;
      @(negedge clk);
    end
    if (dcyc > 0) begin
      funct = 6'h10; valid_i = 1'b1;
      @(negedge clk);
      h = result; funct = 6'h12;
      @(negedge clk);
      l = result; valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic v, z, il;
    logic [31:0] r;
    reset = 1'b1; valid_i = 1'b0; aluop = '0; funct = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    checks++;
    if ({valid_o, zero, illegal, done_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b want=0000", {valid_o, zero, illegal, done_o});
    end
    checks++;
    if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
    reset = 1'b0;
    run_op(2'b10, 6'h10, 32'd0, 32'd0, v, r, z, il);
    checks++;
    if ({v, r, z} !== {1'b1, 32'd0, 1'b1}) begin
      failures++; $display("FAIL reset_hi got=%b/%h want=1/0", v, r);
    end
    run_op(2'b10, 6'h12, 32'd0, 32'd0, v, r, z, il);
    checks++;
    if ({v, r, z} !== {1'b1, 32'd0, 1'b1}) begin
      failures++; $display("FAIL reset_lo got=%b/%h want=1/0", v, r);
    end
  endtask

  task automatic test_directed_alu();
    logic v, z, il;
    logic [31:0] r;
    run_op(2'b10, 6'h22, 32'd5, 32'd5, v, r, z, il);
    checks++;
    if ({v, r, z, il} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sub_zero got v=%b r=%h z=%b il=%b want 1/0/1/0", v, r, z, il);
    end
    run_op(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, v, r, z, il);
    checks++;
    if ({v, r, z} !== {1'b1, 32'd1, 1'b0}) begin
      failures++; $display("FAIL slt_neg got v=%b r=%h z=%b want 1/1/0", v, r, z);
    end
    run_op(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1, v, r, z, il);
    checks++;
    if ({v, r, z} !== {1'b1, 32'd0, 1'b1}) begin
      failures++; $display("FAIL sltu_big got v=%b r=%h z=%b want 1/0/1", v, r, z);
    end
    run_op(2'b10, 6'h3F, 32'h1234, 32'h5678, v, r, z, il);
    checks++;
    if ({v, r, z, il} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL illegal_3f got v=%b r=%h z=%b il=%b want 1/0/1/1", v, r, z, il);
    end
    run_op(2'b00, 6'h3F, 32'hFFFF_FFFF, 32'd2, v, r, z, il);
    checks++;
    if ({v, r, il} !== {1'b1, 32'd1, 1'b0}) begin
      failures++; $display("FAIL add_wrap got v=%b r=%h il=%b want 1/1/0", v, r, il);
    end
  endtask

  task automatic test_mult();
    logic [5:0] fn;
    logic [31:0] x, y, eh, el, h, l;
    int lat, rlow, vcnt, dcyc;
    for (int i = 0; i < 5; i++) begin
      fn = (i == 0 || $urandom_range(0, 1) == 0) ? 6'h18 : 6'h19;
      x = (i == 0) ? -32'sd3 : $urandom;
      y = (i == 0) ? 32'd7 : $urandom;
      model_muldiv(fn, x, y, eh, el, lat);
      run_muldiv(fn, x, y, rlow, vcnt, dcyc, h, l);
      checks++;
      if (dcyc != lat) begin failures++; $display("FAIL mult_done_cycle got=%0d want=%0d", dcyc, lat); end
      checks++;
      if (rlow != lat - 1) begin failures++; $display("FAIL mult_ready_low got=%0d want=%0d", rlow, lat - 1); end
      checks++;
      if (vcnt != 0) begin failures++; $display("FAIL mult_valid_pulse got=%0d want=0", vcnt); end
      checks++;
      if ({h, l} !== {eh, el}) begin
        failures++; $display("FAIL mult_hilo fn=%h a=%h b=%h got=%h_%h want=%h_%h", fn, x, y, h, l, eh, el);
      end
      m_hi = eh; m_lo = el;
    end
  endtask

  // Back-to-back random single-cycle ops, one accepted every cycle
  task automatic test_back_to_back();
    logic [5:0] fn_tab [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h3F};
    logic [31:0] corner [4] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
    logic [1:0] op;
    logic [5:0] fn;
    logic [31:0] x, y, er;
    logic eil;
    bit have = 1'b0;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      if (have) begin
        checks++;
        if ({valid_o, result, zero, illegal} !== {1'b1, er, er == 32'd0, eil}) begin
          failures++;
          $display("FAIL b2b_op%0d op=%0d fn=%h got v=%b r=%h z=%b il=%b want r=%h il=%b",
                   i, op, fn, valid_o, result, zero, illegal, er, eil);
        end
      end
      if (i == 60) begin valid_i = 1'b0; break; end
      op = 2'($urandom_range(0, 3));
      fn = fn_tab[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      if (fn == 6'h18 || fn == 6'h19 || (div_en() && (fn == 6'h1A || fn == 6'h1B))) fn = 6'h3F;
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      model_alu(op, fn, x, y, er, eil);
      aluop = op; funct = fn; a = x; b = y; valid_i = 1'b1;
      have = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b want=0", valid_o); end
  endtask

  task automatic test_div();
`ifdef ALU_MULDIV_DIV_EN
    logic [5:0] fn_d [5] = '{6'h1B, 6'h1A, 6'h1A, 6'h1A, 6'h1B};
    logic [31:0] x_d [5] = '{32'd100, -32'sd7, 32'd9, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] y_d [5] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [5:0] fn;
    logic [31:0] x, y, eh, el, h, l;
    int lat, rlow, vcnt, dcyc;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        fn = fn_d[i]; x = x_d[i]; y = y_d[i];
      end else begin
        fn = ($urandom_range(0, 1) == 0) ? 6'h1A : 6'h1B;
        x = $urandom;
        y = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
        if ($urandom_range(0, 1) == 0) y = -y;
      end
      model_muldiv(fn, x, y, eh, el, lat);
      run_muldiv(fn, x, y, rlow, vcnt, dcyc, h, l);
      checks++;
      if (dcyc != lat) begin failures++; $display("FAIL div_done_cycle got=%0d want=%0d", dcyc, lat); end
      checks++;
      if (rlow != lat - 1) begin failures++; $display("FAIL div_ready_low got=%0d want=%0d", rlow, lat - 1); end
      checks++;
      if ({h, l} !== {eh, el} || vcnt != 0) begin
        failures++;
        $display("FAIL div_hilo fn=%h a=%h b=%h got=%h_%h want=%h_%h vpulses=%0d",
                 fn, x, y, h, l, eh, el, vcnt);
      end
      m_hi = eh; m_lo = el;
    end
`else
    logic v, z, il;
    logic [31:0] r;
    run_op(2'b10, 6'h1A, 32'd9, 32'd3, v, r, z, il);
    checks++;
    if ({v, r, z, il} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL div_illegal got v=%b r=%h z=%b il=%b want 1/0/1/1", v, r, z, il);
    end
    run_op(2'b10, 6'h1B, 32'd9, 32'd3, v, r, z, il);
    checks++;
    if ({v, r, il} !== {1'b1, 32'd0, 1'b1} || ready_o !== 1'b1 || done_o !== 1'b0) begin
      failures++; $display("FAIL divu_illegal got v=%b r=%h il=%b rdy=%b", v, r, il, ready_o);
    end
    run_op(2'b10, 6'h10, 32'd0, 32'd0, v, r, z, il);
    checks++;
    if (r !== m_hi) begin failures++; $display("FAIL div_hi_kept got=%h want=%h", r, m_hi); end
`endif
  endtask

  task automatic test_reset_mid();
    logic v, z, il;
    logic [31:0] r;
    int dones = 0;
    @(negedge clk);
    aluop = 2'b10; funct = 6'h18; a = $urandom | 32'h1; b = $urandom | 32'h1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ready_o, done_o, valid_o} !== 3'b100) begin
      failures++; $display("FAIL midreset_async got rdy/done/v=%b want=100", {ready_o, done_o, valid_o});
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    run_op(2'b10, 6'h10, 32'd0, 32'd0, v, r, z, il);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL midreset_hi got=%h want=0", r); end
    run_op(2'b10, 6'h12, 32'd0, 32'd0, v, r, z, il);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL midreset_lo got=%h want=0", r); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL midreset_done got=%0d pulses want=0", dones); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed_alu();
    test_mult();
    test_back_to_back();
    test_div();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
